// File: rtl/cmd_write.sv
// SD CMD-line transmitter: frames index/argument into a 48-bit token with CRC7,
// drives the shared pad with an output enable and enforces the Ncc recovery gap.
module cmd_write #(
    parameter int unsigned NccCycles = 8
) (
    input  logic        sd_clk_i,
    input  logic        rst_i,
    input  logic        start_tx_i,
    input  logic [5:0]  cmd_index_i,
    input  logic [31:0] cmd_arg_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        start_listening_o,
    output logic        cmd_o,
    output logic        cmd_oe_o
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFrame    = 3'd1,
        StCrc      = 3'd2,
        StEnd      = 3'd3,
        StRecovery = 3'd4
    } state_e;

    localparam logic [5:0] NccLast = 6'(NccCycles - 1);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [6:0]  crc_q, crc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        listen_q, listen_d;
    logic        cmd_q, cmd_d;
    logic        oe_q, oe_d;
    logic        fb;

    // All outputs are registered from the current state, so cycle k shows the
    // decision taken at edge k.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        crc_d    = crc_q;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        listen_d = 1'b0;
        cmd_d    = 1'b1;
        oe_d     = 1'b0;
        fb       = shift_q[39] ^ crc_q[6];
        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start_tx_i) begin
                    shift_d = {2'b01, cmd_index_i, cmd_arg_i};
                    crc_d   = 7'h00;
                    cnt_d   = 6'd0;
                    state_d = StFrame;
                end
            end
            StFrame: begin
                cmd_d   = shift_q[39];
                oe_d    = 1'b1;
                shift_d = {shift_q[38:0], 1'b0};
                crc_d   = {crc_q[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
                if (cnt_q == 6'd39) begin
                    cnt_d   = 6'd0;
                    state_d = StCrc;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StCrc: begin
                cmd_d = crc_q[3'd6 - cnt_q[2:0]];
                oe_d  = 1'b1;
                if (cnt_q == 6'd6) begin
                    cnt_d   = 6'd0;
                    state_d = StEnd;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StEnd: begin
                oe_d    = 1'b1;
                cnt_d   = 6'd0;
                state_d = StRecovery;
            end
            StRecovery: begin
                done_d   = (cnt_q == 6'd0);
                listen_d = (cnt_q == 6'd1);
                if (cnt_q == NccLast) begin
                    cnt_d   = 6'd0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                cnt_d   = 6'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= 6'd0;
            shift_q  <= 40'd0;
            crc_q    <= 7'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            listen_q <= 1'b0;
            cmd_q    <= 1'b1;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            crc_q    <= crc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            listen_q <= listen_d;
            cmd_q    <= cmd_d;
            oe_q     <= oe_d;
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign start_listening_o = listen_q;
    assign cmd_o             = cmd_q;
    assign cmd_oe_o          = oe_q;

endmodule

// File: doc/cmd_write.md
# cmd_write

Serial transmitter for SD commands on the CMD line, the host-to-card counterpart of the response receiver. It accepts a 6-bit command index and a 32-bit argument and frames them into a 48-bit token: start bit, transmission bit, index, argument, CRC7 and end bit. It computes the CRC7 on the fly, drives the shared CMD pad with an output enable, and pulses a listen-start strobe for the response receiver. It enforces a recovery gap before the next command is accepted.

## Interface
- `NccCycles`, default 8: idle CMD cycles after the end bit before a new command is accepted; must be ≥ 2.
- `sd_clk_i` in 1: SD clock; all logic on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_tx_i` in 1: request; sampled only in IDLE.
- `cmd_index_i` in 6: command index; captured when the request is accepted.
- `cmd_arg_i` in 32: command argument; captured when the request is accepted.
- `busy_o` out 1: transmitter not in IDLE.
- `done_o` out 1: one-cycle pulse after the end bit.
- `start_listening_o` out 1: one-cycle pulse for the response receiver.
- `cmd_o` out 1: serial CMD data, registered.
- `cmd_oe_o` out 1: CMD pad output enable, registered.

## Operation
- States: IDLE, SEND_FRAME, SEND_CRC, SEND_END, RECOVERY.
- IDLE:
  - `cmd_o`=1, `cmd_oe_o`=0.
  - If `start_tx_i`=1, latch the 40-bit header {1'b0, 1'b1, `cmd_index_i`, `cmd_arg_i`} into a shift register.
  - Clear CRC to 0, clear the 6-bit counter, go to SEND_FRAME.
- SEND_FRAME:
  - Shift out the 40 header bits MSB first.
  - Each output bit b updates the CRC: fb = b ^ crc[6]; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00). The polynomial is x^7+x^3+1.
  - After 40 bits, go to SEND_CRC.
- SEND_CRC:
  - Shift out crc[6:0] MSB first over 7 cycles; the CRC does not update.
  - Then go to SEND_END.
- SEND_END: drive `cmd_o`=1 for one cycle, then go to RECOVERY.
- RECOVERY:
  - `cmd_oe_o`=0, `cmd_o`=1.
  - The counter runs for NccCycles cycles, then go to IDLE.
- `start_tx_i` outside IDLE is ignored and not queued.
- `cmd_index_i` and `cmd_arg_i` may change freely after acceptance; only the latched copy is transmitted.
- The counter is 6 bits and never wraps within a state. It is cleared on every state change.
- Unreachable state encodings go to IDLE with the outputs at their reset values.

## Timing
- Reset values, applied immediately and asynchronously, including mid-frame:
  - `cmd_o`=1, `cmd_oe_o`=0, `busy_o`=0, `done_o`=0, `start_listening_o`=0, state IDLE.
  - The partial frame is abandoned and nothing is resumed after reset release.
- Cycle 0 is the edge at which `start_tx_i`=1 is sampled in IDLE. Cycle k means the output valid after edge k.
- Cycles 1..48: `cmd_oe_o`=1.
  - Cycle k drives frame bit 48−k.
  - Cycle 1 = start bit 0, cycle 2 = transmission bit 1.
  - Cycles 3..8 = index, cycles 9..40 = argument.
  - Cycles 41..47 = CRC7, cycle 48 = end bit 1.
- Cycle 49: `cmd_oe_o`=0, `done_o`=1.
- Cycle 50: `start_listening_o`=1, the second cycle after the end bit.
- `busy_o`=1 in cycles 1..48+NccCycles; it is 0 from cycle 49+NccCycles.
- A request sampled at edge 49+NccCycles is accepted; its start bit appears at cycle 50+NccCycles.
- Back-to-back commands therefore have a minimum start-bit spacing of 49+NccCycles cycles.
- `start_tx_i` held high continuously yields consecutive commands at exactly that spacing.

## Test plan
- Reset released, no request, idle 20 cycles → `cmd_o`=1, `cmd_oe_o`=0, all pulses 0 throughout.
- CMD0, arg 0x00000000 → serial frame 48'h40_0000_0000_95 (CRC7 0x4A); `done_o` at cycle 49; `start_listening_o` at cycle 50.
- CMD8, arg 0x000001AA → frame 48'h48_0000_01AA_87; CMD17, arg 0 → frame 48'h51_0000_0000_55.
- Change `cmd_index_i`/`cmd_arg_i` and pulse `start_tx_i` at cycle 20 of an active frame → frame unchanged; no second frame starts.
- `start_tx_i` held high, NccCycles=8 → second start bit at cycle 58; `cmd_oe_o` low in cycles 49..57.
- Assert `rst_i` at cycle 25 for 1 cycle → `cmd_o`=1 and `cmd_oe_o`=0 in the same cycle; `busy_o`=0; no `done_o`; a new request after release transmits a clean full frame.
